// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: register file geometry
// and the width/limit of the debug transfer counter.
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  localparam int COUNT_W = 16;
  typedef logic [COUNT_W-1:0] count_t;
  localparam count_t COUNT_MAX = '1;

  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating
// pointer, and moves the pointer one past the winner whenever a grant is taken.
module rr_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = ptrWidth(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grantIdx
);

  logic [PTR_W-1:0] rrPtr;
  logic [PTR_W:0]   cand;
  logic             found;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, rrPtr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(N)) cand = cand - (PTR_W+1)'(N);
      if (!found && req[cand[PTR_W-1:0]]) begin
        found    = 1'b1;
        grantIdx = cand[PTR_W-1:0];
      end
    end
    // Nothing may be accepted while reset is held.
    if (found && !reset) grant[grantIdx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rrPtr <= '0;
    end else if (advance) begin
      rrPtr <= (grantIdx == PTR_W'(N-1)) ? '0 : grantIdx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single write port of the register file between NUM_REQ writeback
// sources with round-robin valid/ready handshakes and a registered write port.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        reqValid,
  output logic [NUM_REQ-1:0]        reqReady,
  input  logic [NUM_REQ*ADDR_W-1:0] reqRegister,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  output logic                      regWrite,
  output logic [ADDR_W-1:0]         writeRegister,
  output logic [DATA_W-1:0]         writeData,
  output logic [15:0]               grantCount
);

  localparam int PTR_W = ptrWidth(NUM_REQ);

  function automatic count_t satInc(input count_t c);
    return (c == COUNT_MAX) ? c : c + 1'b1;
  endfunction

  logic [PTR_W-1:0]  grantIdx;
  logic              acceptP0;
  logic              writesRegP0;
  logic [ADDR_W-1:0] selRegisterP0;
  logic [DATA_W-1:0] selDataP0;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .clk      (clk),
    .reset    (reset),
    .req      (reqValid),
    .advance  (acceptP0),
    .grant    (reqReady),
    .grantIdx (grantIdx)
  );

  // Stage p0: grant and source select, all combinational.
  assign acceptP0      = |reqReady;
  assign selRegisterP0 = reqRegister[grantIdx*ADDR_W +: ADDR_W];
  assign selDataP0     = reqData[grantIdx*DATA_W +: DATA_W];
  // Register 0 is hard-wired; its transfers complete but never reach the port.
  assign writesRegP0   = acceptP0 && (selRegisterP0 != ADDR_W'(ZERO_REG));

  // Stage p1: registered write port and transfer counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
      grantCount    <= '0;
    end else begin
      regWrite <= writesRegP0;
      if (writesRegP0) begin
        writeRegister <= selRegisterP0;
        writeData     <= selDataP0;
      end
      if (acceptP0) grantCount <= satInc(grantCount);
    end
  end

endmodule
